alu_issue_ctrl: RTL

//  Upstream issue/capture stage for the 16-bit reversible-logic ALU array (WIDTH chained one-bit slices).

---
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/capture controller for the chained reversible-logic ALU slices: accepts one op,
// drives the slice buses for a fixed settle window, then captures and offers the result.
module alu_issue_ctrl #(
    parameter int WIDTH      = 16,
    parameter int SETTLE_CYC = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [4:0]       in_sel,
    input  logic             in_cin,
    input  logic             in_fill,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_sel,
    output logic             alu_cin,
    output logic [WIDTH-1:0] alu_amin,
    output logic [WIDTH-1:0] alu_aplus,
    output logic [WIDTH-1:0] alu_cmin,
    output logic [WIDTH-1:0] alu_cplus,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic [15:0]      ops_done
);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [4:0]       sel_q, sel_d;
    logic             cin_q, cin_d, fill_q, fill_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
    logic [15:0]      ops_q, ops_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            cin_q   <= 1'b0;
            fill_q  <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            cin_q   <= cin_d;
            fill_q  <= fill_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ops_q   <= ops_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        cin_d   = cin_q;
        fill_d  = fill_q;
        res_d   = res_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        carry_d = carry_q;
        ops_d   = ops_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sel_d   = in_sel;
                    cin_d   = in_cin;
                    fill_d  = in_fill;
                    cnt_d   = CNT_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    res_d   = alu_y;
                    zero_d  = (alu_y == '0);
                    neg_d   = alu_y[WIDTH-1];
                    // Only the arithmetic path produces a meaningful carry out.
                    carry_d = (sel_q[4:3] == 2'b01) ? alu_cout : 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    ops_d   = ops_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_sel = sel_q;
    assign alu_cin = cin_q;

    // Neighbour buses come from registered A only, so they move only on accept edges.
    assign alu_amin  = {a_q[WIDTH-2:0], fill_q};
    assign alu_aplus = {fill_q, a_q[WIDTH-1:1]};
    assign alu_cmin  = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
    assign alu_cplus = {a_q[0], a_q[WIDTH-1:1]};

    assign out_res   = res_q;
    assign out_zero  = zero_q;
    assign out_neg   = neg_q;
    assign out_carry = carry_q;
    assign ops_done  = ops_q;

endmodule
